// File: rtl/cpu_mc_if.sv
// Host/debug/status bundle for the cpu_mc core: the host side drives load, start and debug-address signals.
// The core side returns the debug read data and the registered execution state.
interface cpu_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int IW = 4 + ADDR_W;
  localparam int PW = (IW > DATA_W) ? IW : DATA_W;

  logic              start;
  logic              prog_we;
  logic              prog_sel;
  logic [ADDR_W-1:0] prog_addr;
  logic [PW-1:0]     prog_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic              zf;
  logic              cf;
  logic              busy;
  logic              halt;

  modport master (
    output start, prog_we, prog_sel, prog_addr, prog_data, dbg_addr,
    input  dbg_data, pc, acc, zf, cf, busy, halt
  );

  modport slave (
    input  start, prog_we, prog_sel, prog_addr, prog_data, dbg_addr,
    output dbg_data, pc, acc, zf, cf, busy, halt
  );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle accumulator core: 2 cycles per instruction (FETCH, EXEC); results are visible the cycle after the EXEC edge.
// There is no backpressure: start is ignored while busy, and host writes are accepted only in IDLE or HALT.
module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  cpu_mc_if.slave bus
);
  localparam int IW    = 4 + ADDR_W;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            state;
  logic [IW-1:0]     ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic              zf;
  logic              cf;
  logic              busy;
  logic              halt;

  logic [IW-1:0]     imem [DEPTH];
  logic [DATA_W-1:0] dmem [DEPTH];

  logic [3:0]        op;
  logic [ADDR_W-1:0] opr;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              host_ok;

  assign op      = ir[IW-1 -: 4];
  assign opr     = ir[ADDR_W-1:0];
  assign mem_rd  = dmem[opr];
  assign sum     = {1'b0, acc} + {1'b0, mem_rd};
  assign diff    = {1'b0, acc} - {1'b0, mem_rd};
  assign host_ok = bus.prog_we && (state == S_IDLE || state == S_HALT);

  assign bus.dbg_data = dmem[bus.dbg_addr];
  assign bus.pc       = pc;
  assign bus.acc      = acc;
  assign bus.zf       = zf;
  assign bus.cf       = cf;
  assign bus.busy     = busy;
  assign bus.halt     = halt;

  // Memories keep their contents across reset; a reset during EXEC clears state, so no STA write can follow.
  always_ff @(posedge clk) begin
    if (host_ok && !bus.prog_sel)
      imem[bus.prog_addr] <= bus.prog_data[IW-1:0];
    if (host_ok && bus.prog_sel)
      dmem[bus.prog_addr] <= bus.prog_data[DATA_W-1:0];
    else if (state == S_EXEC && op == OP_STA)
      dmem[opr] <= acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      pc    <= '0;
      acc   <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      busy  <= 1'b0;
      halt  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state <= S_FETCH;
            pc    <= '0;
            halt  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc + 1'b1;
          case (op)
            OP_LDA: begin
              acc <= mem_rd;
              zf  <= (mem_rd == '0);
            end
            OP_ADD: begin
              acc <= sum[DATA_W-1:0];
              cf  <= sum[DATA_W];
              zf  <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              acc <= diff[DATA_W-1:0];
              cf  <= diff[DATA_W];
              zf  <= (diff[DATA_W-1:0] == '0);
            end
            OP_LDI: begin
              acc <= DATA_W'(opr);
              zf  <= (opr == '0);
            end
            OP_JMP: pc <= opr;
            OP_JZ:  if (zf) pc <= opr;
            OP_JC:  if (cf) pc <= opr;
            OP_HLT: begin
              // pc stays on the HLT address so the host can see where it stopped
              pc    <= pc;
              state <= S_HALT;
              busy  <= 1'b0;
              halt  <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc at 8/4 and 16/5 widths; each halt event is checked against a queue of expected results.
module tb_cpu_mc;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mc_if #(.DATA_W(8),  .ADDR_W(4)) h8 ();
  cpu_mc_if #(.DATA_W(16), .ADDR_W(5)) h16 ();

  cpu_mc #(.DATA_W(8),  .ADDR_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(h8));
  cpu_mc #(.DATA_W(16), .ADDR_W(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(h16));

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] acc;
    logic        zf;
    logic        cf;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input int pc, input int acc, input int zf, input int cf);
    exp_t e;
    e.pc  = pc[7:0];
    e.acc = acc;
    e.zf  = zf[0];
    e.cf  = cf[0];
    if (d == 0) q8.push_back(e);
    else q16.push_back(e);
  endtask

  function automatic int ins(input int d, input int op, input int opr);
    return (d == 0) ? ((op << 4) | opr) : ((op << 5) | opr);
  endfunction

  task automatic wr(input int d, input logic sel, input int a, input int data);
    if (d == 0) begin
      h8.prog_we = 1'b1; h8.prog_sel = sel; h8.prog_addr = a[3:0]; h8.prog_data = data[7:0];
    end else begin
      h16.prog_we = 1'b1; h16.prog_sel = sel; h16.prog_addr = a[4:0]; h16.prog_data = data[15:0];
    end
    tick();
    h8.prog_we  = 1'b0;
    h16.prog_we = 1'b0;
  endtask

  task automatic clr_imem(input int d);
    for (int i = 0; i < ((d == 0) ? 16 : 32); i++) wr(d, 1'b0, i, 0);
  endtask

  task automatic start_pulse(input int d);
    if (d == 0) h8.start = 1'b1;
    else h16.start = 1'b1;
    tick();
    h8.start  = 1'b0;
    h16.start = 1'b0;
  endtask

  task automatic wait_halt(input int d, input string name);
    int n;
    n = 0;
    while (!((d == 0) ? h8.halt : h16.halt) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_chk++;
      $display("FAIL %s: no halt within 300 cycles", name);
    end
    tick();
  endtask

  // Scoreboard: every rising halt consumes one expected record.
  initial begin : monitor
    logic prev8, prev16;
    exp_t e;
    prev8  = 1'b0;
    prev16 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (h8.halt && !prev8) begin
        if (q8.size() == 0) begin
          n_chk++;
          $display("FAIL halt8_unexpected: halted at pc 0x%0h, expected no halt", h8.pc);
        end else begin
          e = q8.pop_front();
          chk("halt8_pc",  32'(h8.pc),  32'(e.pc));
          chk("halt8_acc", 32'(h8.acc), e.acc);
          chk("halt8_zf",  32'(h8.zf),  32'(e.zf));
          chk("halt8_cf",  32'(h8.cf),  32'(e.cf));
        end
      end
      if (h16.halt && !prev16) begin
        if (q16.size() == 0) begin
          n_chk++;
          $display("FAIL halt16_unexpected: halted at pc 0x%0h, expected no halt", h16.pc);
        end else begin
          e = q16.pop_front();
          chk("halt16_pc",  32'(h16.pc),  32'(e.pc));
          chk("halt16_acc", 32'(h16.acc), e.acc);
          chk("halt16_zf",  32'(h16.zf),  32'(e.zf));
          chk("halt16_cf",  32'(h16.cf),  32'(e.cf));
        end
      end
      prev8  = h8.halt;
      prev16 = h16.halt;
    end
  end

  initial begin : stim
    h8.start = 1'b0;  h8.prog_we = 1'b0;  h8.prog_sel = 1'b0;  h8.prog_addr = '0;  h8.prog_data = '0;  h8.dbg_addr = '0;
    h16.start = 1'b0; h16.prog_we = 1'b0; h16.prog_sel = 1'b0; h16.prog_addr = '0; h16.prog_data = '0; h16.dbg_addr = '0;
    repeat (3) tick();
    chk("rst_pc",   32'(h8.pc),   0);
    chk("rst_acc",  32'(h8.acc),  0);
    chk("rst_zf",   32'(h8.zf),   0);
    chk("rst_cf",   32'(h8.cf),   0);
    chk("rst_busy", 32'(h8.busy), 0);
    chk("rst_halt", 32'(h8.halt), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of the ADD EXEC cycle
    clr_imem(0);
    wr(0, 1'b1, 2, 7);
    wr(0, 1'b1, 4, 9);
    wr(0, 1'b0, 0, ins(0, 5, 3));
    wr(0, 1'b0, 1, ins(0, 3, 2));
    wr(0, 1'b0, 2, ins(0, 2, 4));
    wr(0, 1'b0, 3, ins(0, 15, 0));
    start_pulse(0);
    repeat (3) tick();
    chk("t1_pre_busy", 32'(h8.busy), 1);
    chk("t1_pre_acc",  32'(h8.acc),  3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_acc",  32'(h8.acc),  0);
    chk("t1_rst_pc",   32'(h8.pc),   0);
    chk("t1_rst_busy", 32'(h8.busy), 0);
    tick();
    rst_n = 1'b1;
    h8.dbg_addr = 4'd4;
    tick();
    chk("t1_dmem4_kept", 32'(h8.dbg_data), 9);
    chk("t1_post_acc",   32'(h8.acc),  0);
    chk("t1_post_zf",    32'(h8.zf),   0);
    chk("t1_post_busy",  32'(h8.busy), 0);
    push_exp(0, 3, 10, 0, 0);
    start_pulse(0);
    wait_halt(0, "t1_run");
    chk("t1_dmem4_sta", 32'(h8.dbg_data), 10);

    // LDI/STA/ADD/HLT with cycle-exact halt timing and read-before-write on dbg
    clr_imem(0);
    wr(0, 1'b1, 3, 8'h33);
    wr(0, 1'b0, 0, ins(0, 5, 5));
    wr(0, 1'b0, 1, ins(0, 2, 3));
    wr(0, 1'b0, 2, ins(0, 3, 3));
    wr(0, 1'b0, 3, ins(0, 15, 0));
    h8.dbg_addr = 4'd3;
    push_exp(0, 3, 8'h0A, 0, 0);
    start_pulse(0);
    repeat (3) tick();
    chk("t2_dbg_old", 32'(h8.dbg_data), 8'h33);
    tick();
    chk("t2_dbg_new", 32'(h8.dbg_data), 5);
    repeat (3) tick();
    chk("t2_halt_c8", 32'(h8.halt), 0);
    tick();
    chk("t2_halt_c9", 32'(h8.halt), 1);
    chk("t2_pc",      32'(h8.pc),   3);
    tick();

    // Restart from HALT; imem write during the run must be ignored
    push_exp(0, 3, 8'h0A, 0, 0);
    start_pulse(0);
    chk("t6_pc0",   32'(h8.pc),   0);
    chk("t6_halt0", 32'(h8.halt), 0);
    chk("t6_busy",  32'(h8.busy), 1);
    chk("t6_acc",   32'(h8.acc),  8'h0A);
    tick();
    wr(0, 1'b0, 2, ins(0, 15, 0));
    wait_halt(0, "t6_run1");
    push_exp(0, 3, 8'h0A, 0, 0);
    start_pulse(0);
    wait_halt(0, "t6_run2");

    // ADD overflow to zero, JZ taken
    clr_imem(0);
    wr(0, 1'b1, 0, 8'hFF);
    wr(0, 1'b0, 0, ins(0, 5, 1));
    wr(0, 1'b0, 1, ins(0, 3, 0));
    wr(0, 1'b0, 2, ins(0, 7, 6));
    wr(0, 1'b0, 3, ins(0, 15, 0));
    wr(0, 1'b0, 6, ins(0, 15, 0));
    push_exp(0, 6, 0, 1, 1);
    start_pulse(0);
    wait_halt(0, "t3_run");

    // SUB with borrow, JC taken
    clr_imem(0);
    wr(0, 1'b1, 0, 3);
    wr(0, 1'b0, 0, ins(0, 5, 2));
    wr(0, 1'b0, 1, ins(0, 4, 0));
    wr(0, 1'b0, 2, ins(0, 8, 5));
    wr(0, 1'b0, 3, ins(0, 15, 0));
    wr(0, 1'b0, 4, ins(0, 15, 0));
    wr(0, 1'b0, 5, ins(0, 15, 0));
    push_exp(0, 5, 8'hFF, 0, 1);
    start_pulse(0);
    wait_halt(0, "t4_run");

    // JZ not taken falls through; cf survives LDI
    clr_imem(0);
    wr(0, 1'b0, 0, ins(0, 5, 1));
    wr(0, 1'b0, 1, ins(0, 7, 5));
    wr(0, 1'b0, 2, ins(0, 15, 0));
    wr(0, 1'b0, 5, ins(0, 15, 0));
    push_exp(0, 2, 1, 0, 1);
    start_pulse(0);
    wait_halt(0, "t5_jz_nt");

    // JMP to the last address, NOP there wraps pc to 0: endless loop
    clr_imem(0);
    wr(0, 1'b0, 0, ins(0, 6, 15));
    wr(0, 1'b0, 1, ins(0, 15, 0));
    start_pulse(0);
    chk("t5_pc_a", 32'(h8.pc), 0);
    repeat (2) tick();
    chk("t5_pc_b", 32'(h8.pc), 15);
    repeat (2) tick();
    chk("t5_pc_wrap", 32'(h8.pc), 0);
    repeat (40) tick();
    chk("t5_loop_busy", 32'(h8.busy), 1);
    chk("t5_loop_halt", 32'(h8.halt), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Wide core: same program, then LDA/ADD with carry out of 16 bits
    clr_imem(1);
    wr(1, 1'b0, 0, ins(1, 5, 5));
    wr(1, 1'b0, 1, ins(1, 2, 3));
    wr(1, 1'b0, 2, ins(1, 3, 3));
    wr(1, 1'b0, 3, ins(1, 15, 0));
    h16.dbg_addr = 5'd3;
    push_exp(1, 3, 16'h000A, 0, 0);
    start_pulse(1);
    wait_halt(1, "w_run1");
    chk("w_dmem3", 32'(h16.dbg_data), 5);
    wr(1, 1'b1, 7, 16'hFFFF);
    wr(1, 1'b0, 0, ins(1, 1, 7));
    wr(1, 1'b0, 1, ins(1, 3, 7));
    wr(1, 1'b0, 2, ins(1, 15, 0));
    push_exp(1, 2, 16'hFFFE, 0, 1);
    start_pulse(1);
    wait_halt(1, "w_run2");

    repeat (3) tick();
    chk("q8_drained",  q8.size(),  0);
    chk("q16_drained", q16.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
